seq_mult8: RTL and testbench



---
 rtl/seq_mult8_pkg.sv | 21 ++
 rtl/seq_mult8_rca.sv | 35 +++
 rtl/seq_mult8.sv | 138 +++++++++++++
 tb/tb_seq_mult8.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult8_pkg.sv
// ----------------------------------------------------------------------------
// seq_mult8_pkg
// Shared definitions for the sequential 8x8 shift-add multiplier:
//   - state_e  : FSM state encoding (IDLE, RUN, DONE)
//   - OP_W     : operand width (8)
//   - PROD_W   : product width (16)
//   - CNT_W    : step counter width (3, counts steps 0..7)
// ----------------------------------------------------------------------------
package seq_mult8_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_mult8_pkg

// File: rtl/seq_mult8_rca.sv
// ----------------------------------------------------------------------------
// RCA
// 8-bit ripple-carry adder, the multiplier's only arithmetic element.
// Ports (positional order is fixed by existing users):
//   s         out 8  sum
//   Carry_out out 1  carry out of bit 7
//   x         in  8  addend
//   y         in  8  addend
//   Carry_in  in  1  carry into bit 0
// ----------------------------------------------------------------------------
module RCA
    import seq_mult8_pkg::*;
(
    output logic [OP_W-1:0] s,
    output logic            Carry_out,
    input  logic [OP_W-1:0] x,
    input  logic [OP_W-1:0] y,
    input  logic            Carry_in
);

    logic [OP_W:0] carry_s;

    // Full-adder chain; carry_s[i] is the carry into bit i.
    always_comb begin
        carry_s    = '0;
        s          = '0;
        carry_s[0] = Carry_in;
        for (int i = 0; i < OP_W; i++) begin
            s[i]         = x[i] ^ y[i] ^ carry_s[i];
            carry_s[i+1] = (x[i] & y[i]) | (carry_s[i] & (x[i] ^ y[i]));
        end
        Carry_out = carry_s[OP_W];
    end

endmodule : RCA

// File: rtl/seq_mult8.sv
// ----------------------------------------------------------------------------
// seq_mult8
// Sequential 8x8 unsigned shift-add multiplier, one partial-product step per
// clock, using a single RCA instance as the arithmetic element.
// Ports:
//   clk   in  1   rising-edge clock
//   rst   in  1   asynchronous active-high reset
//   start in  1   request a multiply (accepted in IDLE or DONE)
//   a     in  8   multiplicand, captured on accept
//   b     in  8   multiplier, captured on accept
//   busy  out 1   high while stepping (RUN)
//   done  out 1   one-cycle pulse when p holds a new result
//   p     out 16  product, held until the next completion
// Build option:
//   SEQ_MULT8_ZERO_BYPASS_EN - when defined, an accept with a zero operand
//   goes straight to DONE with p=0 instead of running the 8 steps.
// ----------------------------------------------------------------------------
module seq_mult8
    import seq_mult8_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] p
);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        state_q, state_d;
    logic [OP_W-1:0]   mcand_q, mcand_d;
    logic [OP_W-1:0]   acc_hi_q, acc_hi_d;
    logic [OP_W-1:0]   acc_lo_q, acc_lo_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PROD_W-1:0] p_q, p_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [OP_W-1:0]   addend_s;
    logic [OP_W-1:0]   sum_s;
    logic              carry_s;
    logic [PROD_W-1:0] shifted_s;

    // The multiplicand is added only when the current multiplier LSB is set.
    assign addend_s = acc_lo_q[0] ? mcand_q : {OP_W{1'b0}};

    RCA u_rca (
        .s         (sum_s),
        .Carry_out (carry_s),
        .x         (acc_hi_q),
        .y         (addend_s),
        .Carry_in  (1'b0)
    );

    // 17-bit {carry,sum,acc_lo} shifted right by one; carry becomes the MSB.
    assign shifted_s = {carry_s, sum_s, acc_lo_q[OP_W-1:1]};

    // Next-state, datapath and output decode.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    mcand_d  = a;
                    acc_hi_d = {OP_W{1'b0}};
                    acc_lo_d = b;
                    cnt_d    = {CNT_W{1'b0}};
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
                    if ((a == 8'h00) || (b == 8'h00)) begin
                        state_d = ST_DONE;
                        p_d     = 16'h0000;
                    end else begin
                        state_d = ST_RUN;
                    end
`else
                    state_d = ST_RUN;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_hi_d = shifted_s[PROD_W-1:OP_W];
                acc_lo_d = shifted_s[OP_W-1:0];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    p_d     = shifted_s;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers; reset discards any in-flight multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mcand_q  <= 8'h00;
            acc_hi_q <= 8'h00;
            acc_lo_q <= 8'h00;
            cnt_q    <= 3'd0;
            p_q      <= 16'h0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign p    = p_q;

endmodule : seq_mult8

// File: tb/tb_seq_mult8.sv
// ----------------------------------------------------------------------------
// tb_seq_mult8
// Directed self-checking bench for seq_mult8. Inputs change one time unit
// after a rising edge; outputs are sampled on falling edges.
// ----------------------------------------------------------------------------
module tb_seq_mult8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int n_cmp;
    int n_bad;
    int cyc;
    int done_cnt;
    int overlap_cnt;

    seq_mult8 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (busy && done) overlap_cnt <= overlap_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits for done; 'at' is the number of falling edges seen (0 = timeout).
    task automatic wait_done(output int at, output int nbusy);
        at    = 0;
        nbusy = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (done) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic do_mult(input string tag, input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] exp_p, input int exp_at, input int exp_busy);
        int at;
        int nb;
        @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        wait_done(at, nb);
        chk({tag, "_done_at"}, at, exp_at);
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_p"}, {16'h0000, p}, {16'h0000, exp_p});
    endtask

    initial begin
        int at;
        int nb;
        int d0;
        int t1;
        int t2;
        n_cmp       = 0;
        n_bad       = 0;
        cyc         = 0;
        done_cnt    = 0;
        overlap_cnt = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;

        // Reset then idle
        repeat (2) @(negedge clk);
        chk("rst_p", {16'h0000, p}, 32'h0000_0000);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_p", {16'h0000, p}, 32'h0000_0000);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done_cnt", done_cnt, 0);

        // Basic products
        do_mult("m0f0f", 8'h0F, 8'h0F, 16'h00E1, 9, 8);
        do_mult("mffff", 8'hFF, 8'hFF, 16'hFE01, 9, 8);
        @(negedge clk);
        chk("hold_p", {16'h0000, p}, 32'h0000_FE01);
        chk("hold_done", {31'd0, done}, 32'd0);

        // Busy protection: start with new operands during steps 3..5 is ignored
        @(negedge clk);
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h05;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0    = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        wait_done(at, nb);
        chk("busyprot_done_at", at, 4);
        chk("busyprot_p", {16'h0000, p}, 32'h0000_000F);
        repeat (4) @(negedge clk);
        chk("busyprot_done_pulses", done_cnt - d0, 1);
        chk("busyprot_idle_busy", {31'd0, busy}, 32'd0);

        // Back-to-back: start held through DONE
        @(negedge clk);
        start = 1'b1;
        a     = 8'h12;
        b     = 8'h34;
        @(posedge clk);
        #1;
        a     = 8'hAB;
        b     = 8'hCD;
        wait_done(at, nb);
        t1 = cyc;
        chk("b2b1_done_at", at, 9);
        chk("b2b1_p", {16'h0000, p}, 32'h0000_03A8);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        wait_done(at, nb);
        t2 = cyc;
        chk("b2b2_done_at", at, 9);
        chk("b2b2_busy_cycles", nb, 8);
        chk("b2b2_p", {16'h0000, p}, 32'h0000_88EF);
        chk("b2b_spacing", t2 - t1, 9);

        // Reset mid-operation
        @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        d0    = done_cnt;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_p", {16'h0000, p}, 32'h0000_0000);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_hold_p", {16'h0000, p}, 32'h0000_0000);
        do_mult("m0203", 8'h02, 8'h03, 16'h0006, 9, 8);

        // Zero operand
`ifdef SEQ_MULT8_ZERO_BYPASS_EN
        do_mult("zero", 8'h00, 8'h55, 16'h0000, 1, 0);
`else
        do_mult("zero", 8'h00, 8'h55, 16'h0000, 9, 8);
`endif

        repeat (2) @(negedge clk);
        chk("busy_done_overlap", overlap_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_seq_mult8
